// File: rtl/serdesphy_rx_aligner.sv
// RX nibble aligner: hunts for SYNC_WORD in the recovered bitstream, locks nibble boundaries, emits 4-bit words.
// Build option SERDESPHY_RX_ALIGN_STATS_EN adds the sync_err_count output (saturating LOCKED error count).
module serdesphy_rx_aligner #(
    parameter logic [7:0]  SYNC_WORD   = 8'hBC,
    parameter int unsigned CONFIRM_CNT = 3,
    parameter int unsigned LOSS_CNT    = 4
) (
    input  logic       clk_240m_rx,
    input  logic       rst_n_240m_rx,
    input  logic       rx_serial_data,
    input  logic       rx_serial_valid,
    input  logic       rx_serial_error,
    input  logic       rx_align_rst,
    output logic [3:0] rx_word,
    output logic       rx_word_valid,
    output logic       rx_aligned,
    output logic       sync_det,
    output logic       align_err
`ifdef SERDESPHY_RX_ALIGN_STATS_EN
    ,
    output logic [7:0] sync_err_count
`endif
);
    localparam logic [2:0] CONFIRM_C = 3'(CONFIRM_CNT);
    localparam logic [2:0] LOSS_C    = 3'(LOSS_CNT);

    typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;
    state_t state, state_nxt;

    // Only the 7 newest bits are stored; the 8th bit of every window is the live input.
    logic [6:0] sr;
    logic [7:0] sr_shift;
    logic [1:0] bit_cnt, bit_cnt_nxt;
    logic [2:0] conf_cnt, conf_nxt, conf_inc;
    logic [2:0] err_cnt, err_nxt, err_inc;
    logic       match, nib_end, match_al, match_mis, bit_err, lock_err;
    logic [3:0] word_nxt;
    logic       word_vld_nxt, align_err_nxt;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    assign sr_shift  = {sr, rx_serial_data};
    assign match     = rx_serial_valid && (sr_shift == SYNC_WORD);
    assign nib_end   = rx_serial_valid && (bit_cnt == 2'd3);
    assign match_al  = match && nib_end;
    assign match_mis = match && !nib_end;
    assign bit_err   = rx_serial_valid && rx_serial_error;
    assign lock_err  = (state == LOCKED) && (match_mis || bit_err);
    assign conf_inc  = sat_inc3(conf_cnt);
    assign err_inc   = sat_inc3(err_cnt);

    always_ff @(posedge clk_240m_rx or negedge rst_n_240m_rx) begin
        if (!rst_n_240m_rx) state <= HUNT;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (rx_align_rst) begin
            state_nxt = HUNT;
        end else begin
            case (state)
                HUNT:    if (match) state_nxt = (CONFIRM_C == 3'd1) ? LOCKED : VERIFY;
                VERIFY:  if (bit_err) state_nxt = HUNT;
                         else if (match_al && (conf_inc >= CONFIRM_C)) state_nxt = LOCKED;
                LOCKED:  if (lock_err && (err_inc >= LOSS_C)) state_nxt = HUNT;
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        bit_cnt_nxt   = bit_cnt;
        conf_nxt      = conf_cnt;
        err_nxt       = err_cnt;
        word_nxt      = rx_word;
        word_vld_nxt  = 1'b0;
        align_err_nxt = 1'b0;
        if (rx_align_rst) begin
            bit_cnt_nxt = 2'd0;
            conf_nxt    = 3'd0;
            err_nxt     = 3'd0;
        end else begin
            if (rx_serial_valid) bit_cnt_nxt = bit_cnt + 2'd1;
            case (state)
                HUNT: if (match) begin
                    bit_cnt_nxt = 2'd0;
                    conf_nxt    = 3'd1;
                end
                VERIFY: begin
                    if (bit_err) begin
                        conf_nxt = 3'd0;
                    end else if (match_al) begin
                        conf_nxt = conf_inc;
                    end else if (match) begin
                        bit_cnt_nxt = 2'd0;
                        conf_nxt    = 3'd1;
                    end
                end
                LOCKED: begin
                    if (nib_end) begin
                        word_nxt     = sr_shift[3:0];
                        word_vld_nxt = 1'b1;
                    end
                    if (lock_err) begin
                        align_err_nxt = 1'b1;
                        err_nxt       = (err_inc >= LOSS_C) ? 3'd0 : err_inc;
                    end else if (match_al) begin
                        err_nxt = 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs: one cycle after the qualifying input bit.
    always_ff @(posedge clk_240m_rx or negedge rst_n_240m_rx) begin
        if (!rst_n_240m_rx) begin
            sr            <= '0;
            bit_cnt       <= '0;
            conf_cnt      <= '0;
            err_cnt       <= '0;
            rx_word       <= '0;
            rx_word_valid <= 1'b0;
            rx_aligned    <= 1'b0;
            sync_det      <= 1'b0;
            align_err     <= 1'b0;
        end else begin
            if (rx_serial_valid) sr <= sr_shift[6:0];
            bit_cnt       <= bit_cnt_nxt;
            conf_cnt      <= conf_nxt;
            err_cnt       <= err_nxt;
            rx_word       <= word_nxt;
            rx_word_valid <= word_vld_nxt;
            rx_aligned    <= (state_nxt == LOCKED);
            sync_det      <= match;
            align_err     <= align_err_nxt;
        end
    end

`ifdef SERDESPHY_RX_ALIGN_STATS_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk_240m_rx or negedge rst_n_240m_rx) begin
        if (!rst_n_240m_rx)     sync_err_count <= '0;
        else if (rx_align_rst)  sync_err_count <= '0;
        else if (align_err_nxt) sync_err_count <= sat_inc8(sync_err_count);
    end
`endif
endmodule

// File: doc/serdesphy_rx_aligner.md
# serdesphy_rx_aligner

Receive-side nibble aligner between the deserializer interface and the RX FIFO/PRBS checker in the 240 MHz RX domain. It takes the recovered serial bitstream (`rx_serial_data`/`rx_serial_valid`) and hunts for the 8-bit sync word. It locks nibble boundaries after repeated aligned sync detections, then emits 4-bit words with a valid strobe and drives `rx_aligned`.

## Interface
- `SYNC_WORD`, 8'hBC, sync pattern; the MSB is received first.
- `CONFIRM_CNT`, 3, total aligned sync detections required to lock (legal range 1..7).
- `LOSS_CNT`, 4, consecutive alignment errors that drop lock (legal range 1..7).

Ports:
- `clk_240m_rx` input 1: RX clock, from CDR.
- `rst_n_240m_rx` input 1: asynchronous, active-low reset.
- `rx_serial_data` input 1: serial bit, sampled only when valid.
- `rx_serial_valid` input 1: bit-valid qualifier.
- `rx_serial_error` input 1: bit error flag, qualified by valid.
- `rx_align_rst` input 1: synchronous alignment restart, from CSR.
- `rx_word` output 4: aligned nibble; the first-received bit is bit 3.
- `rx_word_valid` output 1: one-cycle strobe per nibble.
- `rx_aligned` output 1: high in LOCKED.
- `sync_det` output 1: one-cycle pulse on any sync-word match.
- `align_err` output 1: one-cycle pulse on each LOCKED alignment error.

## Operation
- Shift register `sr[7:0]`: on each valid bit, `sr <= {sr[6:0], rx_serial_data}`. Bits with valid low are ignored entirely.
- `match` = valid & (`{sr[6:0], rx_serial_data}` == `SYNC_WORD`).
- Bit counter `bit_cnt[1:0]` advances on each valid bit and wraps 3→0.
  - A nibble completes on a valid bit with `bit_cnt`==3.
  - An aligned match is a match with `bit_cnt`==3. Any other match is misaligned.
- HUNT (reset state):
  - No word output.
  - On match: `bit_cnt`←0, `conf_cnt`←1, go to VERIFY. If `CONFIRM_CNT`==1, go directly to LOCKED.
- VERIFY:
  - Aligned match: `conf_cnt`++. When it reaches `CONFIRM_CNT`, go to LOCKED.
  - Misaligned match: re-anchor with `bit_cnt`←0, `conf_cnt`←1, and stay in VERIFY.
  - Valid bit with `rx_serial_error`: go to HUNT.
  - No word output.
- LOCKED:
  - Every completed nibble is output, including sync nibbles: `rx_word` ← `{sr[2:0], rx_serial_data}`, `rx_word_valid` pulses.
  - Alignment error = misaligned match OR (valid & `rx_serial_error`). Each error event increments `err_cnt` once, even if both causes occur in the same cycle, and pulses `align_err`.
  - Aligned match with no error clears `err_cnt`.
  - When `err_cnt` reaches `LOSS_CNT`, go to HUNT. The nibble completing in that same cycle is still output.
- `rx_align_rst` high:
  - Next state HUNT; `conf_cnt`, `err_cnt` and `bit_cnt` are cleared; `sr` is kept.
  - It overrides every other transition and suppresses `rx_word_valid`/`align_err` in that cycle.
- The nibble that confirms lock (VERIFY→LOCKED) is not output. The first output is the next nibble.
- Counters are 3 bits and saturate; they never wrap.

## Timing
- Reset values: `rx_word`=0, `rx_word_valid`=0, `rx_aligned`=0, `sync_det`=0, `align_err`=0, state HUNT, `sr`=0, all counters 0.
- All outputs are registered. Latency from the valid edge of a nibble's 4th bit to `rx_word`/`rx_word_valid` is 1 cycle.
- `rx_word` holds its value between strobes.
- `rx_aligned` rises 1 cycle after the confirming match edge and falls 1 cycle after the loss or `rx_align_rst` edge.
- `sync_det` is asserted in any state, 1 cycle after the match.
- Back-to-back valid bits: 4 cycles per nibble minimum. Arbitrary valid gaps are tolerated.

## Configuration
- `SERDESPHY_RX_ALIGN_STATS_EN`:
  - Defined: adds output `sync_err_count[7:0]`. It is a saturating count (max 255) of LOCKED alignment errors, reset to 0, cleared by `rx_align_rst`, and not cleared by loss of lock.
  - Undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset mid-stream, then feed "101" followed by `SYNC_WORD` ×3 with continuous valid → `sync_det` ×3, `rx_aligned` 1 cycle after the 27th bit, no `rx_word_valid` before lock.
- After lock, send nibbles 0x1,0x2,0xF → `rx_word_valid` ×3 with `rx_word` 0x1,0x2,0xF, each 1 cycle after its 4th bit.
- In LOCKED, insert 4 single-bit-slipped sync words → `align_err` ×4, `rx_aligned`=0 after the 4th, no further nibbles output.
- In LOCKED, 3 `rx_serial_error` bits followed by an aligned sync → `err_cnt` returns to 0 and lock is held. A 4th error later does not drop lock.
- In VERIFY, a sync word appears at 2-bit offset → re-anchor. Two more aligned syncs at the new phase are needed to lock.
- Assert `rx_align_rst` during a nibble in LOCKED → `rx_aligned`=0 next cycle, no strobe that cycle, relock needs 3 syncs. With STATS_EN, `sync_err_count` reads 0.
